debounce_entradas: RTL and testbench
====================================

DEBOUNCE_ENTRADAS -- requirements
Module: debounce_entradas

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000 (integer >= 2): consecutive stable synchronized cycles required before an output changes.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports btn_a, btn_b, btn_c, input, 1 bit each: raw push-button/switch levels, asynchronous to clk, bouncing.
REQ-005 SHALL have ports a, b, c, output logic, 1 bit each: debounced levels driving the downstream a/b/c logic-function stage.
REQ-006 SHALL have port changed, output logic, 1 bit: one-cycle pulse flagging that at least one of a/b/c toggled.

Function
REQ-007 SHALL process three identical, independent channels: btn_a->a, btn_b->b, btn_c->c.
REQ-008 SHALL pass each raw input through a 2-flop synchronizer (s1, s2) before any other use.
REQ-009 SHALL run, per channel, a 2-state FSM: ESTAVEL (s2 == output, counter = 0) and CONTANDO (s2 != output, counter running).
REQ-010 SHALL transition ESTAVEL->CONTANDO on the first edge where s2 != output, loading counter = 1.
REQ-011 SHALL increment the counter in CONTANDO on each edge where s2 != output, remaining in CONTANDO.
REQ-012 SHALL return to ESTAVEL in CONTANDO on any edge where s2 == output (bounce), clearing the counter and leaving the output unchanged.
REQ-013 SHALL toggle the output on the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 != output, then enter ESTAVEL with counter = 0.
REQ-014 SHALL produce a clean raw transition sampled first at edge k at the output at edge k+1+DEBOUNCE_CYCLES, i.e. the (DEBOUNCE_CYCLES+2)th edge counting k as the first.
REQ-015 SHALL size the counter at $clog2(DEBOUNCE_CYCLES+1) bits, and the counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-016 SHALL register changed high for exactly the one cycle following any edge on which a, b or c toggles, and low otherwise.
REQ-017 SHALL, when several channels toggle on the same edge, raise changed as a single one-cycle pulse.
REQ-018 SHALL, when toggles occur on consecutive edges, hold changed high on both corresponding cycles.
REQ-019 SHALL keep outputs a/b/c glitch-free: each changes only at a clk edge and only per REQ-013.

Reset
REQ-020 SHALL, while rst_n = 0, immediately and asynchronously force a = b = c = 0, changed = 0, s1 = s2 = 0, counters = 0, and all FSMs to ESTAVEL.
REQ-021 SHALL, on reset assertion mid-count, abandon the count; after release, a raw level still held high SHALL reach the output after the full REQ-014 latency measured from the first post-release edge.
REQ-022 SHALL treat a raw input held high across reset release like a fresh 0->1 transition.

Structure
REQ-023 SHALL place the FSM state enum (ESTAVEL, CONTANDO) and the default DEBOUNCE_CYCLES constant in shared package debounce_pkg.
REQ-024 SHALL implement one channel (synchronizer, counter, FSM) as sub-module debounce_canal, instantiated three times; the top SHALL contain only the instances and the changed logic.
REQ-025 SHALL contain no latches, no combinational loops and no clock gating.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 SHALL test a reset value: with rst_n = 0 and all btn = 1, a/b/c/changed = 0; after release, a/b/c = 1 at the 6th edge and changed = 1 for exactly one cycle afterwards.
REQ-027 SHALL test a clean edge: btn_a 0->1 held, first sampled at edge k -> a = 1 at edge k+5, b = c = 0, and one changed pulse.
REQ-028 SHALL test bounce: btn_b pattern 1,0,1,1,0 on successive edges, then held 1 -> b stays 0 through the bounce and goes 1 only 5 edges after the final 0->1 sample.
REQ-029 SHALL test a simultaneous change: btn_a and btn_c rise on the same edge -> a and c toggle on the same edge, with a single one-cycle changed pulse.
REQ-030 SHALL test a mid-count reset: btn_c high for 3 edges, rst_n pulsed low asynchronously between edges -> c = 0 immediately, then c = 1 five edges after release.
REQ-031 SHALL test a release edge: a = 1 stable, btn_a 1->0 held -> a = 0 after 5 edges, with one changed pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the push-button debouncer: the per-channel FSM
// state encoding, the default stability window and the channel count.
package debounce_pkg;

    // ESTAVEL : synchronized input matches the debounced output
    // CONTANDO: they differ, and we are counting consecutive differing cycles
    typedef enum logic {
        ESTAVEL  = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int NUM_CANAIS          = 3;

endpackage

// File: rtl/debounce_canal.sv
// debounce_canal
// One debounce channel: a 2-flop synchronizer followed by a stability
// counter FSM. The output flips only after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive FSM evaluations.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   btn        : raw bouncing input, asynchronous to clk
//   saida      : debounced level (registered)
//   toggle     : high in the cycle whose closing edge flips saida
module debounce_canal
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic saida,
    output logic toggle
);

    // Wide enough for DEBOUNCE_CYCLES; the count never passes DEBOUNCE_CYCLES-1.
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ULT = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    estado_t       estado, estado_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            estado <= ESTAVEL;
            cnt    <= '0;
            saida  <= 1'b0;
        end else begin
            s1     <= btn;
            s2     <= s1;
            estado <= estado_nxt;
            cnt    <= cnt_nxt;
            saida  <= saida ^ toggle;
        end
    end

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        toggle     = 1'b0;
        case (estado)
            ESTAVEL: begin
                if (s2 != saida) begin
                    estado_nxt = CONTANDO;
                    cnt_nxt    = CW'(1);
                end else begin
                    cnt_nxt    = '0;
                end
            end
            CONTANDO: begin
                if (s2 == saida) begin
                    // bounce: drop the count, output untouched
                    estado_nxt = ESTAVEL;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_ULT) begin
                    toggle     = 1'b1;
                    estado_nxt = ESTAVEL;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt    = cnt + CW'(1);
                end
            end
            default: begin
                estado_nxt = ESTAVEL;
                cnt_nxt    = '0;
            end
        endcase
    end

endmodule

// File: rtl/debounce_entradas.sv
// debounce_entradas
// Debounces three independent raw inputs and flags, one cycle later,
// any edge on which at least one debounced output flipped.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   btn_a, btn_b, btn_c : raw bouncing inputs
//   a, b, c             : debounced levels
//   changed             : one-cycle pulse after any of a/b/c toggles
module debounce_entradas
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a,
    input  logic btn_b,
    input  logic btn_c,
    output logic a,
    output logic b,
    output logic c,
    output logic changed
);

    logic [NUM_CANAIS-1:0] btn_vec, saida_vec, tgl_vec;

    assign btn_vec   = {btn_c, btn_b, btn_a};
    assign a         = saida_vec[0];
    assign b         = saida_vec[1];
    assign c         = saida_vec[2];

    for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_canal (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn_vec[i]),
            .saida  (saida_vec[i]),
            .toggle (tgl_vec[i])
        );
    end

    // Registered alongside the outputs, so the pulse covers exactly the
    // cycle after the toggling edge; simultaneous toggles merge naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) changed <= 1'b0;
        else        changed <= |tgl_vec;
    end

endmodule

// File: tb/tb_debounce_entradas.sv
// Directed bench for debounce_entradas with DEBOUNCE_CYCLES = 4.
// Edge 1 of each loop is the first edge that samples the new raw level;
// the debounced output must flip on edge 6 (1 + 1 + 4).
module tb_debounce_entradas;

    logic clk, rst_n, btn_a, btn_b, btn_c;
    logic a, b, c, changed;
    int   total = 0;
    int   bad   = 0;

    debounce_entradas #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
        .a(a), .b(b), .c(c), .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all inputs high
        rst_n = 1'b0; btn_a = 1'b1; btn_b = 1'b1; btn_c = 1'b1;
        tick(); tick();
        chk("rst_a", a, 1'b0);
        chk("rst_b", b, 1'b0);
        chk("rst_c", c, 1'b0);
        chk("rst_chg", changed, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("rel_a_e%0d", i), a, i >= 6);
            chk($sformatf("rel_chg_e%0d", i), changed, i == 6);
        end
        chk("rel_b", b, 1'b1);
        chk("rel_c", c, 1'b1);

        // bring everything low
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("low_a", a, 1'b0);
        chk("low_b", b, 1'b0);
        chk("low_c", c, 1'b0);

        // clean rising edge on btn_a
        btn_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("rise_a_e%0d", i), a, i >= 6);
            chk($sformatf("rise_chg_e%0d", i), changed, i == 6);
        end
        chk("rise_b", b, 1'b0);
        chk("rise_c", c, 1'b0);

        // release edge on btn_a
        btn_a = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("fall_a_e%0d", i), a, i < 6);
            chk($sformatf("fall_chg_e%0d", i), changed, i == 6);
        end

        // bounce on btn_b: 1,0,1,1,0 then held 1 from edge 6 -> b rises on edge 11
        for (int i = 1; i <= 12; i++) begin
            case (i)
                1, 3, 4: btn_b = 1'b1;
                2, 5:    btn_b = 1'b0;
                default: btn_b = 1'b1;
            endcase
            tick();
            chk($sformatf("bnc_b_e%0d", i), b, i >= 11);
            chk($sformatf("bnc_chg_e%0d", i), changed, i == 11);
        end

        // simultaneous rise on a and c
        btn_a = 1'b1; btn_c = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("sim_a_e%0d", i), a, i >= 6);
            chk($sformatf("sim_c_e%0d", i), c, i >= 6);
            chk($sformatf("sim_chg_e%0d", i), changed, i == 6);
        end
        chk("sim_b", b, 1'b1);

        // clear a and c again
        btn_a = 1'b0; btn_c = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("clr_a", a, 1'b0);
        chk("clr_c", c, 1'b0);

        // mid-count reset on c
        btn_b = 1'b0; btn_c = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_c_pre", c, 1'b0);
        chk("mid_b_pre", b, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_b_async", b, 1'b0);
        chk("mid_c_async", c, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("mid_c_e%0d", i), c, i >= 6);
            chk($sformatf("mid_chg_e%0d", i), changed, i == 6);
        end
        chk("mid_a", a, 1'b0);
        chk("mid_b", b, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
